// File: rtl/exp2_bf16_if.sv
// Operand/result bundle for the bfloat16 2^x unit; same port set as the flog unit.
interface exp2_bf16_if #(
    parameter int MAN = 7,
    parameter int EXP = 8
);
    logic           sign;
    logic [EXP-1:0] exponent;
    logic [MAN-1:0] fractional;
    logic           input_valid;
    logic           ready_o;
    logic           s_res_o;
    logic [EXP-1:0] e_res_o;
    logic [MAN-1:0] f_res_o;
    logic           valid_o;

    modport master (output sign, exponent, fractional, input_valid,
                    input  ready_o, s_res_o, e_res_o, f_res_o, valid_o);
    modport slave  (input  sign, exponent, fractional, input_valid,
                    output ready_o, s_res_o, e_res_o, f_res_o, valid_o);
endinterface

// File: rtl/exp2_bf16.sv
// y = 2^x in bfloat16: split x into integer/fraction, build 2^frac one bit per
// cycle from the constants 2^(2^-i), then repack with the integer part as exponent.
module exp2_bf16 #(
    parameter int MAN  = 7,
    parameter int EXP  = 8,
    parameter int BIAS = 127,
    parameter int FRAC = 16
) (
    input  logic       clk,
    input  logic       rst,
    exp2_bf16_if.slave io
);
    localparam int IW = 9;
    localparam int XW = IW + FRAC;
    localparam int AW = FRAC + 2;
    localparam int KW = FRAC + 1;
    localparam int PW = AW + KW;
    localparam int SW = EXP + 3;
    localparam int CW = $clog2(FRAC);
    localparam int LW = $clog2(XW);

    // Entry n holds round(2^(2^-(n+1)) * 2^FRAC); only valid for FRAC=16.
    localparam logic [KW-1:0] K_TAB [FRAC] = '{
        17'd92682, 17'd77936, 17'd71468, 17'd68438,
        17'd66971, 17'd66250, 17'd65892, 17'd65714,
        17'd65625, 17'd65580, 17'd65558, 17'd65547,
        17'd65542, 17'd65539, 17'd65537, 17'd65537
    };

    typedef enum logic [2:0] {IDLE, CONVERT, ITERATE, NORMALIZE, DONE} state_t;

    state_t                state_q, state_d;
    logic                  sign_q, sign_d;
    logic [EXP-1:0]        exp_q, exp_d;
    logic [MAN-1:0]        man_q, man_d;
    logic signed [IW-1:0]  ip_q, ip_d;
    logic [FRAC-1:0]       fp_q, fp_d;
    logic                  zero_q, zero_d, spec_q, spec_d, big_q, big_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [EXP-1:0]        res_e_q, res_e_d, e_out_q, e_out_d;
    logic [MAN-1:0]        res_f_q, res_f_d, f_out_q, f_out_d;
    logic                  valid_q, valid_d;

    logic signed [SW-1:0]  sh, amt, e_big;
    logic [SW-1:0]         neg_amt;
    logic [XW-1:0]         base, mag, x_val;
    logic [PW-1:0]         prod;
    logic [MAN:0]          rnd;

    always_comb begin : datapath
        sh      = $signed({{(SW-EXP){1'b0}}, exp_q}) - $signed(SW'(BIAS));
        amt     = sh + $signed(SW'(FRAC - MAN));
        neg_amt = SW'(0) - $unsigned(amt);
        base    = {{(XW-MAN-1){1'b0}}, 1'b1, man_q};
        mag     = amt[SW-1] ? (base >> neg_amt) : (base << amt[LW-1:0]);
        x_val   = sign_q ? (XW'(0) - mag) : mag;
        prod    = PW'(acc_q) * PW'(K_TAB[cnt_q]);
        rnd     = {1'b0, acc_q[FRAC-1 -: MAN]} + (MAN+1)'(acc_q[FRAC-1-MAN]);
        // A rounding carry out of the mantissa bumps the exponent by one.
        e_big   = $signed({{(SW-IW){ip_q[IW-1]}}, ip_q}) + $signed(SW'(BIAS))
                  + $signed(SW'(rnd[MAN]));
    end

    always_comb begin : fsm
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        man_d   = man_q;
        ip_d    = ip_q;
        fp_d    = fp_q;
        zero_d  = zero_q;
        spec_d  = spec_q;
        big_d   = big_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_e_d = res_e_q;
        res_f_d = res_f_q;
        e_out_d = e_out_q;
        f_out_d = f_out_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (io.input_valid) begin
                    sign_d  = io.sign;
                    exp_d   = io.exponent;
                    man_d   = io.fractional;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                ip_d    = $signed(x_val[XW-1 -: IW]);
                fp_d    = x_val[FRAC-1:0];
                zero_d  = (exp_q == '0);
                spec_d  = (exp_q == '1);
                big_d   = (sh >= $signed(SW'(IW - 1)));
                acc_d   = AW'(1) << FRAC;
                cnt_d   = '0;
                state_d = ITERATE;
            end
            ITERATE: begin
                if (fp_q[CW'(FRAC - 1) - cnt_q])
                    acc_d = AW'(prod >> FRAC);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(FRAC - 1))
                    state_d = NORMALIZE;
            end
            NORMALIZE: begin
                res_e_d = '0;
                res_f_d = '0;
                if (spec_q && man_q != '0) begin
                    res_e_d = '1;
                    res_f_d = {1'b1, {(MAN-1){1'b0}}};
                end else if (spec_q || big_q) begin
                    res_e_d = sign_q ? '0 : '1;
                end else if (zero_q) begin
                    res_e_d = EXP'(BIAS);
                end else if (e_big >= $signed(SW'((1 << EXP) - 1))) begin
                    res_e_d = '1;
                end else if (e_big > $signed(SW'(0))) begin
                    res_e_d = e_big[EXP-1:0];
                    res_f_d = rnd[MAN-1:0];
                end
                state_d = DONE;
            end
            DONE: begin
                e_out_d = res_e_q;
                f_out_d = res_f_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            man_q   <= '0;
            ip_q    <= '0;
            fp_q    <= '0;
            zero_q  <= 1'b0;
            spec_q  <= 1'b0;
            big_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_e_q <= '0;
            res_f_q <= '0;
            e_out_q <= '0;
            f_out_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            man_q   <= man_d;
            ip_q    <= ip_d;
            fp_q    <= fp_d;
            zero_q  <= zero_d;
            spec_q  <= spec_d;
            big_q   <= big_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_e_q <= res_e_d;
            res_f_q <= res_f_d;
            e_out_q <= e_out_d;
            f_out_q <= f_out_d;
            valid_q <= valid_d;
        end
    end

    assign io.ready_o = (state_q == IDLE);
    assign io.s_res_o = 1'b0;
    assign io.e_res_o = e_out_q;
    assign io.f_res_o = f_out_q;
    assign io.valid_o = valid_q;
endmodule

// File: tb/tb_exp2_bf16.sv
// Self-checking bench for exp2_bf16: directed literal cases plus random traffic
// against a behavioural 2^x model evaluated with plain integer arithmetic.
module tb_exp2_bf16;
    logic clk = 1'b0;
    logic rst = 1'b1;

    exp2_bf16_if bus ();
    exp2_bf16 dut (.clk(clk), .rst(rst), .io(bus));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int k_tab [1:16];

    // Model state, advanced once per rising edge.
    int          cyc        = 0;
    bit          armed      = 1'b0;
    bit          pending    = 1'b0;
    int          due        = 0;
    int          busy_until = 0;
    int          pulse_cyc  = -1;
    int          acc_cyc    = -1;
    logic [14:0] held       = '0;
    logic [14:0] pend_res   = '0;

    // Expected {exponent, mantissa} of 2^x, following the conversion and
    // iteration rules with truncating fixed-point arithmetic.
    function automatic logic [14:0] model(input logic s, input logic [7:0] e, input logic [6:0] m);
        longint mag, x, ip, fp, acc, mant, ee;
        int sh, r;
        if (e == 8'd255) begin
            if (m != 7'd0) return {8'hFF, 7'h40};
            return s ? 15'd0 : {8'hFF, 7'h00};
        end
        if (e == 8'd0) return {8'd127, 7'd0};
        sh = int'(e) - 127;
        if (sh >= 8) return s ? 15'd0 : {8'hFF, 7'h00};
        if (sh + 9 >= 0) mag = longint'(128 + int'(m)) <<< (sh + 9);
        else begin
            r = -(sh + 9);
            mag = (r >= 8) ? 64'sd0 : (longint'(128 + int'(m)) >>> r);
        end
        x   = s ? -mag : mag;
        ip  = x >>> 16;
        fp  = x & 64'sd65535;
        acc = 65536;
        for (int i = 1; i <= 16; i++)
            if (((fp >> (16 - i)) & 64'sd1) != 0) acc = (acc * longint'(k_tab[i])) >>> 16;
        mant = (acc >>> 9) & 64'sd127;
        if (((acc >>> 8) & 64'sd1) != 0) mant = mant + 1;
        if (mant == 128) begin
            mant = 0;
            ip   = ip + 1;
        end
        ee = ip + 127;
        if (ee >= 255) return {8'hFF, 7'h00};
        if (ee <= 0) return 15'd0;
        return {8'(ee), 7'(mant)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: acceptance only while idle, fixed 19-edge latency, reset aborts.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            armed      = 1'b1;
            pending    = 1'b0;
            busy_until = cyc;
            pulse_cyc  = -1;
            held       = '0;
        end else begin
            if (pending && cyc == due) begin
                held      = pend_res;
                pending   = 1'b0;
                pulse_cyc = cyc;
            end
            if (bus.input_valid && (cyc - 1) >= busy_until) begin
                pend_res   = model(bus.sign, bus.exponent, bus.fractional);
                pending    = 1'b1;
                acc_cyc    = cyc;
                due        = cyc + 19;
                busy_until = due;
            end
        end
    end

    // Compare process: handshake and held result checked every cycle.
    always @(negedge clk) begin
        if (armed) begin
            checkOutput("ctrl", {30'd0, bus.valid_o, bus.ready_o},
                        {30'd0, (pulse_cyc == cyc), (cyc >= busy_until)});
            checkOutput("data", {16'd0, bus.s_res_o, bus.e_res_o, bus.f_res_o}, {17'd0, held});
        end
    end

    // Waits for ready, then presents one operand for a single cycle.
    task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [6:0] m);
        int n = 0;
        while (bus.ready_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.ready_o !== 1'b1) checkOutput("ready_timeout", {31'd0, bus.ready_o}, 32'd1);
        bus.sign        = s;
        bus.exponent    = e;
        bus.fractional  = m;
        bus.input_valid = 1'b1;
        @(negedge clk);
        bus.input_valid = 1'b0;
    endtask

    // Waits (bounded) for the result pulse and compares it with hand-computed values.
    task automatic waitResult(input string name, input logic [7:0] req_e, input logic [6:0] req_f);
        int n = 0;
        while (bus.valid_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.valid_o !== 1'b1) begin
            checkOutput({name, "_timeout"}, {31'd0, bus.valid_o}, 32'd1);
        end else begin
            checkOutput({name, "_latency"}, 32'(cyc - acc_cyc), 32'd19);
            checkOutput(name, {17'd0, bus.e_res_o, bus.f_res_o}, {17'd0, req_e, req_f});
        end
        @(negedge clk);
    endtask

    task automatic runLiteral(input string name, input logic s, input logic [7:0] e,
                              input logic [6:0] m, input logic [7:0] req_e, input logic [6:0] req_f);
        applyStimulus(s, e, m);
        waitResult(name, req_e, req_f);
    endtask

    initial begin
        real r;
        r = 2.0;
        for (int i = 1; i <= 16; i++) begin
            r = $sqrt(r);
            k_tab[i] = $rtoi(r * 65536.0 + 0.5);
        end
        bus.sign        = 1'b0;
        bus.exponent    = '0;
        bus.fractional  = '0;
        bus.input_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_ready", {31'd0, bus.ready_o}, 32'd1);
        checkOutput("reset_out", {16'd0, bus.s_res_o, bus.e_res_o, bus.f_res_o}, 32'd0);

        runLiteral("one",      1'b0, 8'd127, 7'h00, 8'd128, 7'h00);
        runLiteral("neg_one",  1'b1, 8'd127, 7'h00, 8'd126, 7'h00);
        runLiteral("half",     1'b0, 8'd126, 7'h00, 8'd127, 7'h35);
        runLiteral("quarter",  1'b0, 8'd125, 7'h00, 8'd127, 7'h18);
        runLiteral("zero",     1'b0, 8'd0,   7'h00, 8'd127, 7'h00);
        runLiteral("pos_inf",  1'b0, 8'd255, 7'h00, 8'd255, 7'h00);
        runLiteral("neg_inf",  1'b1, 8'd255, 7'h00, 8'd0,   7'h00);
        runLiteral("nan",      1'b0, 8'd255, 7'h01, 8'd255, 7'h40);
        runLiteral("x128",     1'b0, 8'd134, 7'h00, 8'd255, 7'h00);
        runLiteral("m126",     1'b1, 8'd133, 7'h7C, 8'd1,   7'h00);
        runLiteral("m127",     1'b1, 8'd133, 7'h7E, 8'd0,   7'h00);
        runLiteral("x300",     1'b0, 8'd135, 7'h16, 8'd255, 7'h00);

        // A second request while busy must be dropped.
        applyStimulus(1'b0, 8'd127, 7'h00);
        repeat (4) @(negedge clk);
        bus.sign        = 1'b1;
        bus.input_valid = 1'b1;
        checkOutput("busy_ready", {31'd0, bus.ready_o}, 32'd0);
        @(negedge clk);
        bus.input_valid = 1'b0;
        waitResult("ignore_second", 8'd128, 7'h00);
        repeat (25) @(negedge clk);

        // Reset in the middle of the iteration aborts without a result.
        applyStimulus(1'b0, 8'd126, 7'h00);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_ready", {31'd0, bus.ready_o}, 32'd1);
        checkOutput("abort_out", {16'd0, bus.s_res_o, bus.e_res_o, bus.f_res_o}, 32'd0);
        repeat (25) @(negedge clk);
        runLiteral("after_abort", 1'b0, 8'd127, 7'h00, 8'd128, 7'h00);

        $display("[TB] random traffic");
        for (int t = 0; t < 1500; t++) begin
            bus.input_valid = ($urandom_range(0, 3) == 0);
            bus.sign        = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       bus.exponent = 8'($urandom_range(0, 255));
                1:       bus.exponent = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'd255;
                default: bus.exponent = 8'($urandom_range(110, 136));
            endcase
            bus.fractional = 7'($urandom_range(0, 127));
            @(negedge clk);
        end
        bus.input_valid = 1'b0;
        repeat (25) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
